// File: rtl/game_screen_pkg.sv
// Shared screen constants, RGB565 colours and loading-bar state encoding
// for the OLED game screens.
package game_screen_pkg;

  localparam int SCREEN_W = 96;
  localparam int SCREEN_H = 64;

  localparam logic [15:0] C_BG_DEF     = 16'h5FFF;
  localparam logic [15:0] C_BORDER_DEF = 16'h0000;
  localparam logic [15:0] C_FILL_DEF   = 16'h07E0;
  localparam logic [15:0] C_EMPTY_DEF  = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_FLASH,
    ST_DONE
  } lb_state_e;

endpackage

// File: rtl/loading_bar_raster.sv
// Combinational pixel classifier for the loading bar: border ring membership
// and segment hit/index via one range comparator pair per segment.
module loading_bar_raster #(
  parameter int BAR_X0  = 10,
  parameter int BAR_Y0  = 26,
  parameter int BAR_W   = 80,
  parameter int BAR_H   = 24,
  parameter int BORDER  = 3,
  parameter int PAD     = 1,
  parameter int NUM_SEG = 4,
  parameter int GAP     = 1
) (
  input  logic [6:0] x_i,
  input  logic [5:0] y_i,
  output logic       in_border_o,
  output logic       in_seg_o,
  output logic [4:0] seg_idx_o
);

  localparam int OX1   = BAR_X0 + BAR_W - 1;
  localparam int OY1   = BAR_Y0 + BAR_H - 1;
  localparam int SX0   = BAR_X0 + BORDER + PAD;
  localparam int SX1   = BAR_X0 + BAR_W - 1 - BORDER - PAD;
  localparam int SY0   = BAR_Y0 + BORDER + PAD;
  localparam int SY1   = BAR_Y0 + BAR_H - 1 - BORDER - PAD;
  localparam int SEG_W = (SX1 - SX0 + 1 - (NUM_SEG - 1) * GAP) / NUM_SEG;

  int xv;
  int yv;
  logic in_outer;
  logic in_inner;
  logic in_rows;
  logic [NUM_SEG-1:0] hit;

  assign xv = 32'(x_i);
  assign yv = 32'(y_i);

  assign in_outer = (xv >= BAR_X0) && (xv <= OX1) && (yv >= BAR_Y0) && (yv <= OY1);
  assign in_inner = (xv >= BAR_X0 + BORDER) && (xv <= OX1 - BORDER) &&
                    (yv >= BAR_Y0 + BORDER) && (yv <= OY1 - BORDER);
  assign in_border_o = in_outer && !in_inner;
  assign in_rows = (yv >= SY0) && (yv <= SY1);

  // The last segment stretches to SX1 so integer-division leftovers are not lost.
  for (genvar k = 0; k < NUM_SEG; k++) begin : g_seg
    localparam int L = SX0 + k * (SEG_W + GAP);
    localparam int R = (k == NUM_SEG - 1) ? SX1 : (L + SEG_W - 1);
    assign hit[k] = in_rows && (xv >= L) && (xv <= R);
  end

  assign in_seg_o = |hit;

  always_comb begin
    seg_idx_o = 5'd0;
    for (int k = 0; k < NUM_SEG; k++) begin
      if (hit[k]) seg_idx_o = 5'(k);
    end
  end

endmodule

// File: rtl/loading_bar_screen.sv
// Animated loading-bar screen: fill FSM with blink/flash timing driven by
// frame ticks, plus a registered RGB565 pixel output for the OLED mux.
module loading_bar_screen
  import game_screen_pkg::*;
#(
  parameter int          BAR_X0        = 10,
  parameter int          BAR_Y0        = 26,
  parameter int          BAR_W         = 80,
  parameter int          BAR_H         = 24,
  parameter int          BORDER        = 3,
  parameter int          PAD           = 1,
  parameter int          NUM_SEG       = 4,
  parameter int          GAP           = 1,
  parameter int          TICKS_PER_SEG = 15,
  parameter int          BLINK_TICKS   = 8,
  parameter int          DONE_BLINKS   = 3,
  parameter logic [15:0] C_BG          = C_BG_DEF,
  parameter logic [15:0] C_BORDER      = C_BORDER_DEF,
  parameter logic [15:0] C_FILL        = C_FILL_DEF,
  parameter logic [15:0] C_EMPTY       = C_EMPTY_DEF
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        frame_tick_i,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        pause_i,
  input  logic [6:0]  x_i,
  input  logic [5:0]  y_i,
  output logic [15:0] oled_data_o,
  output logic [4:0]  seg_count_o,
  output logic        busy_o,
  output logic        done_o
);

  localparam int FLASH_TOGGLES = 2 * DONE_BLINKS;

  lb_state_e   state_q;
  logic [4:0]  seg_count_q;
  logic [15:0] tick_cnt_q;
  logic [15:0] blink_cnt_q;
  logic [15:0] flash_cnt_q;
  logic        blink_q;
  logic        busy_q;
  logic        done_q;
  logic [15:0] oled_q;
  logic [15:0] pixel_d;

  logic       tick;
  logic       blink_wrap;
  logic       in_border;
  logic       in_seg;
  logic [4:0] seg_idx;

  assign tick       = frame_tick_i && !pause_i;
  assign blink_wrap = (blink_cnt_q == 16'(BLINK_TICKS - 1));

  loading_bar_raster #(
    .BAR_X0 (BAR_X0),
    .BAR_Y0 (BAR_Y0),
    .BAR_W  (BAR_W),
    .BAR_H  (BAR_H),
    .BORDER (BORDER),
    .PAD    (PAD),
    .NUM_SEG(NUM_SEG),
    .GAP    (GAP)
  ) u_raster (
    .x_i        (x_i),
    .y_i        (y_i),
    .in_border_o(in_border),
    .in_seg_o   (in_seg),
    .seg_idx_o  (seg_idx)
  );

  // Blink phase runs continuously across FILL and FLASH; flash_cnt counts its toggles.
  always_ff @(posedge clk_i) begin
    if (reset_i || abort_i) begin
      state_q     <= ST_IDLE;
      seg_count_q <= 5'd0;
      tick_cnt_q  <= 16'd0;
      blink_cnt_q <= 16'd0;
      flash_cnt_q <= 16'd0;
      blink_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (tick && (state_q == ST_FILL || state_q == ST_FLASH)) begin
        if (blink_wrap) begin
          blink_cnt_q <= 16'd0;
          blink_q     <= ~blink_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + 16'd1;
        end
      end
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            state_q     <= ST_FILL;
            seg_count_q <= 5'd0;
            tick_cnt_q  <= 16'd0;
            blink_cnt_q <= 16'd0;
            flash_cnt_q <= 16'd0;
            blink_q     <= 1'b0;
            busy_q      <= 1'b1;
            done_q      <= 1'b0;
          end
        end
        ST_FILL: begin
          if (tick) begin
            if (tick_cnt_q == 16'(TICKS_PER_SEG - 1)) begin
              tick_cnt_q  <= 16'd0;
              seg_count_q <= seg_count_q + 5'd1;
              if (seg_count_q == 5'(NUM_SEG - 1)) begin
                flash_cnt_q <= 16'd0;
                if (FLASH_TOGGLES == 0) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end else begin
                  state_q <= ST_FLASH;
                end
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 16'd1;
            end
          end
        end
        ST_FLASH: begin
          if (tick && blink_wrap) begin
            flash_cnt_q <= flash_cnt_q + 16'd1;
            if (flash_cnt_q == 16'(FLASH_TOGGLES - 1)) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    pixel_d = C_BG;
    if ((32'(x_i) >= 32'(SCREEN_W)) || (32'(y_i) >= 32'(SCREEN_H))) begin
      pixel_d = C_BG;
    end else if (in_border) begin
      pixel_d = C_BORDER;
    end else if (in_seg) begin
      if (seg_idx < seg_count_q) begin
        pixel_d = (state_q == ST_FLASH && !blink_q) ? C_EMPTY : C_FILL;
      end else if (seg_idx == seg_count_q && state_q == ST_FILL) begin
        pixel_d = blink_q ? C_FILL : C_EMPTY;
      end else begin
        pixel_d = C_EMPTY;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) oled_q <= C_BG;
    else         oled_q <= pixel_d;
  end

  assign oled_data_o = oled_q;
  assign seg_count_o = seg_count_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule
